// File: rtl/uart_tx_buffered.sv
// UART transmitter fed by a FIFO_DEPTH-entry write buffer; frames go out back to back.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_buffered #(
  parameter int unsigned CLKS_PER_BIT  = 217,
  parameter int unsigned NUM_DATA_BITS = 8,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_txValid,
  input  logic [NUM_DATA_BITS-1:0] i_txByte,
  output logic                     o_txReady,
  output logic                     o_tx,
  output logic                     o_txActive,
  output logic                     o_txDone
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned ClkW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(NUM_DATA_BITS + 1);

  localparam logic [CntW-1:0] Depth   = CntW'(FIFO_DEPTH);
  localparam logic [ClkW-1:0] ClkLast = ClkW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(NUM_DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
    StParity = 3'd4,
`endif
    StStop   = 3'd3
  } state_e;

  logic [NUM_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]          count_q;
  logic                     push, pop;
  logic [NUM_DATA_BITS-1:0] head;

  state_e                   state_q, state_d;
  logic [ClkW-1:0]          clk_cnt_q, clk_cnt_d;
  logic [BitW-1:0]          bit_idx_q, bit_idx_d;
  logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
  logic                     bit_end;
`ifdef UART_TX_PARITY_EN
  logic                     parity_q, parity_d;
`endif

  assign head      = mem[rd_ptr_q];
  assign o_txReady = (count_q < Depth);
  assign push      = i_txValid & o_txReady;
  assign bit_end   = (clk_cnt_q == ClkLast);

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= i_txByte;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = bit_end ? '0 : clk_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    pop        = 1'b0;
    o_tx       = 1'b1;
    o_txActive = 1'b1;
    o_txDone   = 1'b0;

    unique case (state_q)
      StIdle: begin
        o_txActive = 1'b0;
        clk_cnt_d  = '0;
        if (count_q != '0) begin
          pop      = 1'b1;
          shift_d  = head;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head;
`endif
          state_d  = StStart;
        end
      end
      StStart: begin
        o_tx = 1'b0;
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        o_tx = shift_q[0];
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == BitLast) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        o_tx = parity_q;
        if (bit_end) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_end) begin
          o_txDone = 1'b1;
          // Chain straight into the next frame when a word is waiting.
          if (count_q != '0) begin
            pop      = 1'b1;
            shift_d  = head;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
            state_d  = StStart;
          end else begin
            state_d  = StIdle;
          end
        end
      end
      default: begin
        o_txActive = 1'b0;
        clk_cnt_d  = '0;
        bit_idx_d  = '0;
        state_d    = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based model of the buffered serial line.
module tb_uart_tx_buffered;
  localparam int unsigned CLKS  = 4;
  localparam int unsigned NBITS = 8;
  localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = NBITS + 3;
`else
  localparam int unsigned FRAME_BITS = NBITS + 2;
`endif
  localparam int unsigned FRAME_LEN = FRAME_BITS * CLKS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       o_txReady, o_tx, o_txActive, o_txDone;
  logic [3:0] obs, exp_obs;

  int checks = 0;
  int errors = 0;

  // Model: words waiting in the buffer, and the per-cycle line values of the current frame.
  logic [7:0] mq[$];
  logic       wave[$];

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLKS_PER_BIT (CLKS),
    .NUM_DATA_BITS(NBITS),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_txValid (valid),
    .i_txByte  (data),
    .o_txReady (o_txReady),
    .o_tx      (o_tx),
    .o_txActive(o_txActive),
    .o_txDone  (o_txDone)
  );

  assign obs = {o_tx, o_txActive, o_txDone, o_txReady};

  function automatic void build_frame(input logic [7:0] b);
    logic [FRAME_BITS-1:0] bits;
    bits = '0;
    for (int i = 0; i < int'(NBITS); i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    bits[NBITS+1] = ^b;
`endif
    bits[FRAME_BITS-1] = 1'b1;
    for (int i = 0; i < int'(FRAME_BITS); i++)
      for (int c = 0; c < int'(CLKS); c++) wave.push_back(bits[i]);
  endfunction

  function automatic logic [3:0] model_obs();
    logic t;
    t = (wave.size() == 0) ? 1'b1 : wave[0];
    return {t, wave.size() != 0, wave.size() == 1, mq.size() < DEPTH};
  endfunction

  // Advance one clock, updating the model with what the edge does, then settle.
  task automatic step();
    logic ready_pre;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      wave.delete();
    end else begin
      ready_pre = (mq.size() < DEPTH);
      if (wave.size() > 0) void'(wave.pop_front());
      if (wave.size() == 0 && mq.size() > 0) build_frame(mq.pop_front());
      if (valid && ready_pre) mq.push_back(data);
    end
    exp_obs = model_obs();
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 4'b1001) begin
      errors++;
      $display("FAIL reset_async: got %b want %b", obs, 4'b1001);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (obs !== exp_obs) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %b want %b", i, obs, exp_obs);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [FRAME_BITS-1:0] seq;
    logic [FRAME_LEN-1:0]  cap;
    logic [FRAME_LEN-1:0]  want;
    int act_cnt, done_cnt, done_at;
`ifdef UART_TX_PARITY_EN
    seq = 11'b1_0_10100101_0;
`else
    seq = 10'b1_10100101_0;
`endif
    for (int i = 0; i < int'(FRAME_LEN); i++) want[i] = seq[i/CLKS];
    cap = '0;
    act_cnt = 0; done_cnt = 0; done_at = 0;
    valid = 1'b1; data = 8'hA5;
    step();
    valid = 1'b0; data = 8'hFF;
    for (int i = 0; i < int'(FRAME_LEN) + 10; i++) begin
      checks++;
      if (obs !== exp_obs) begin
        errors++;
        $display("FAIL single cyc %0d: got %b want %b", i, obs, exp_obs);
      end
      step();
      if (o_txActive) begin
        if (act_cnt < int'(FRAME_LEN)) cap[act_cnt] = o_tx;
        act_cnt++;
        if (o_txDone) begin
          done_cnt++;
          done_at = act_cnt;
        end
      end
    end
    checks += 4;
    if (cap !== want) begin
      errors++;
      $display("FAIL single_wave: got %h want %h", cap, want);
    end
    if (act_cnt != int'(FRAME_LEN)) begin
      errors++;
      $display("FAIL single_active_len: got %0d want %0d", act_cnt, FRAME_LEN);
    end
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL single_done_count: got %0d want 1", done_cnt);
    end
    if (done_at != int'(FRAME_LEN)) begin
      errors++;
      $display("FAIL single_done_cycle: got %0d want %0d", done_at, FRAME_LEN);
    end
  endtask

  task automatic test_back_to_back();
    int done_cnt, gap;
    logic seen;
    done_cnt = 0; gap = 0; seen = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      valid = 1'b1; data = 8'(k);
      step();
      checks++;
      if (obs !== exp_obs) begin
        errors++;
        $display("FAIL b2b_write %0d: got %b want %b", k, obs, exp_obs);
      end
      if (o_txActive) seen = 1'b1;
      if (o_txDone) done_cnt++;
    end
    valid = 1'b0;
    checks++;
    if (o_txReady !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_full: got %b want 0", o_txReady);
    end
    for (int i = 0; i < 5 * int'(FRAME_LEN) + 20 && done_cnt < 5; i++) begin
      step();
      checks++;
      if (obs !== exp_obs) begin
        errors++;
        $display("FAIL b2b cyc %0d: got %b want %b", i, obs, exp_obs);
      end
      if (o_txActive) seen = 1'b1;
      else if (seen) gap++;
      if (o_txDone) done_cnt++;
    end
    checks += 2;
    if (done_cnt != 5) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d want 5", done_cnt);
    end
    if (gap != 0) begin
      errors++;
      $display("FAIL b2b_idle_gap: got %0d want 0", gap);
    end
    for (int i = 0; i < int'(CLKS) * 2; i++) step();
  endtask

  task automatic test_overflow_drop();
    int done_cnt;
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin
        checks++;
        if (o_txReady !== 1'b0) begin
          errors++;
          $display("FAIL drop_ready_before_6th: got %b want 0", o_txReady);
        end
      end
      valid = 1'b1; data = 8'h10 + 8'(k);
      step();
      if (o_txDone) done_cnt++;
    end
    valid = 1'b0;
    for (int i = 0; i < 6 * int'(FRAME_LEN); i++) begin
      step();
      checks++;
      if (obs !== exp_obs) begin
        errors++;
        $display("FAIL drop cyc %0d: got %b want %b", i, obs, exp_obs);
      end
      if (o_txDone) done_cnt++;
    end
    checks++;
    if (done_cnt != 5) begin
      errors++;
      $display("FAIL drop_frame_count: got %0d want 5", done_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int act_cnt, done_cnt;
    act_cnt = 0; done_cnt = 0;
    valid = 1'b1; data = 8'h3C;
    step();
    data = 8'h99;
    step();
    valid = 1'b0;
    if (o_txActive) act_cnt++;
    // Stop two cycles into data bit 3.
    for (int i = 0; i < 40 && act_cnt < int'(CLKS) * 4 + 2; i++) begin
      step();
      if (o_txActive) act_cnt++;
    end
    #3 rst_n = 1'b0;
    mq.delete();
    wave.delete();
    #1;
    checks++;
    if (obs !== 4'b1001) begin
      errors++;
      $display("FAIL midframe_reset_async: got %b want %b", obs, 4'b1001);
    end
    step();
    step();
    rst_n = 1'b1;
    act_cnt = 0;
    for (int i = 0; i < int'(FRAME_LEN) + 20; i++) begin
      step();
      checks++;
      if (obs !== exp_obs) begin
        errors++;
        $display("FAIL midframe_after cyc %0d: got %b want %b", i, obs, exp_obs);
      end
      if (o_txDone) done_cnt++;
      if (o_txActive) act_cnt++;
    end
    checks += 2;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL midframe_done_pulses: got %0d want 0", done_cnt);
    end
    if (act_cnt != 0) begin
      errors++;
      $display("FAIL midframe_fifo_not_empty: active cycles %0d want 0", act_cnt);
    end
    valid = 1'b1; data = 8'h5A;
    step();
    valid = 1'b0;
    checks++;
    if (o_tx !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_accept_edge: tx %b want 1", o_tx);
    end
    step();
    checks++;
    if (o_tx !== 1'b0 || o_txActive !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_latency: tx %b active %b want 0 1", o_tx, o_txActive);
    end
    for (int i = 0; i < int'(FRAME_LEN) + 5; i++) begin
      step();
      checks++;
      if (obs !== exp_obs) begin
        errors++;
        $display("FAIL post_reset cyc %0d: got %b want %b", i, obs, exp_obs);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int act_cnt, done_at;
    logic par;
    act_cnt = 0; done_at = 0; par = 1'b0;
    valid = 1'b1; data = 8'h07;
    step();
    valid = 1'b0;
    for (int i = 0; i < int'(FRAME_LEN) + 8; i++) begin
      step();
      if (o_txActive) begin
        act_cnt++;
        if (act_cnt == int'((NBITS + 1) * CLKS) + 2) par = o_tx;
        if (o_txDone) done_at = act_cnt;
      end
    end
    checks += 2;
    if (par !== 1'b1) begin
      errors++;
      $display("FAIL parity_bit: got %b want 1", par);
    end
    if (done_at != 44) begin
      errors++;
      $display("FAIL parity_done_cycle: got %0d want 44", done_at);
    end
  endtask
`endif

  task automatic test_random();
    int thresh [4];
    thresh = '{5, 60, 95, 20};
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 400; i++) begin
        valid = ($urandom_range(0, 99) < thresh[p]);
        data  = 8'($urandom);
        step();
        checks++;
        if (obs !== exp_obs) begin
          errors++;
          $display("FAIL random p%0d cyc %0d: got %b want %b", p, i, obs, exp_obs);
        end
      end
    end
    valid = 1'b0;
    for (int i = 0; i < int'(DEPTH + 2) * int'(FRAME_LEN); i++) begin
      step();
      checks++;
      if (obs !== exp_obs) begin
        errors++;
        $display("FAIL random_drain cyc %0d: got %b want %b", i, obs, exp_obs);
      end
    end
    checks++;
    if (obs !== 4'b1001) begin
      errors++;
      $display("FAIL random_final_idle: got %b want %b", obs, 4'b1001);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow_drop();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 217, giving clock cycles per serial bit (minimum 2).
REQ-002 The block SHALL have parameter NUM_DATA_BITS, default 8, giving data bits per frame (1 to 15).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, giving transmit buffer entries (a power of 2, minimum 2).
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port i_reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port i_txValid, input, 1 bit: the write request for i_txByte.
REQ-007 The block SHALL have port i_txByte, input, NUM_DATA_BITS bits: the data word to transmit.
REQ-008 The block SHALL have port o_txReady, output, 1 bit: high when the buffer is not full.
REQ-009 The block SHALL have port o_tx, output, 1 bit: the serial line, which idles high.
REQ-010 The block SHALL have port o_txActive, output, 1 bit: high while a frame is on the line.
REQ-011 The block SHALL have port o_txDone, output, 1 bit: a one-cycle strobe at the end of each frame.

Function
REQ-012 A write SHALL be accepted on a rising edge where i_txValid=1 and o_txReady=1; the word is pushed into the FIFO tail.
REQ-013 A write with o_txReady=0 SHALL be dropped with no change to FIFO contents or count.
REQ-014 o_txReady SHALL equal (count < FIFO_DEPTH); it is combinational from the registered count.
REQ-015 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL span 0..FIFO_DEPTH inclusive.
REQ-016 A simultaneous accepted push and FSM pop SHALL leave the count unchanged and store both correctly.
REQ-017 The FSM SHALL have states IDLE, START_BIT, DATA_BITS, STOP_BIT, plus PARITY_BIT when UART_TX_PARITY_EN is defined.
REQ-018 In IDLE, o_tx=1 and o_txActive=0; if the FIFO is non-empty the FSM SHALL pop the head word into a shift register and enter START_BIT.
REQ-019 Latency: a write accepted at edge N into an empty FIFO with the FSM in IDLE SHALL drive o_tx=0 from edge N+1.
REQ-020 Each bit SHALL be held on o_tx for exactly CLKS_PER_BIT cycles, counted by a bit-period counter that restarts at 0 on each bit.
REQ-021 START_BIT drives 0; DATA_BITS drives data LSB first, NUM_DATA_BITS bits; STOP_BIT drives 1.
REQ-022 o_txActive SHALL be 1 in every state except IDLE.
REQ-023 o_txDone SHALL pulse high for exactly the final cycle of STOP_BIT.
REQ-024 At the end of STOP_BIT, if the FIFO is non-empty the FSM SHALL pop and enter START_BIT directly with no idle cycle; otherwise it SHALL enter IDLE.
REQ-025 Frame length SHALL be (NUM_DATA_BITS+2)*CLKS_PER_BIT cycles, or (NUM_DATA_BITS+3)*CLKS_PER_BIT with parity.
REQ-026 A change to i_txByte after acceptance SHALL NOT affect buffered or in-flight data.
REQ-027 Illegal FSM encodings SHALL return to IDLE with o_tx=1 on the next edge.

Reset
REQ-028 With i_reset_n=0, outputs SHALL be o_tx=1, o_txActive=0, o_txDone=0 and o_txReady=1, asynchronously and without waiting for a clock edge.
REQ-029 Reset SHALL empty the FIFO (pointers and count to 0), zero the bit and clock counters, and set the FSM to IDLE.
REQ-030 Reset mid-frame SHALL abort the frame immediately, returning the line high, and SHALL discard buffered words.
REQ-031 After i_reset_n rises, the first write SHALL behave as in REQ-019.

Configuration
REQ-032 Macro UART_TX_PARITY_EN defined: PARITY_BIT is inserted between DATA_BITS and STOP_BIT and drives the even parity (XOR) of the data bits for CLKS_PER_BIT cycles.
REQ-033 Macro UART_TX_PARITY_EN undefined: no PARITY_BIT state or parity logic exists, and DATA_BITS proceeds directly to STOP_BIT.

Verification (CLKS_PER_BIT=4, NUM_DATA_BITS=8, FIFO_DEPTH=4)
REQ-034 Single write 0xA5 while idle -> o_tx 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; o_txDone pulses once in cycle 40; o_txActive is high for 40 cycles.
REQ-035 Five back-to-back writes 0x01..0x05 while idle -> the first is popped and 4 are buffered, so none are dropped; o_txReady falls after the fifth; frames follow with no idle gap; 5 o_txDone pulses.
REQ-036 A sixth write while count=4 -> it is dropped; the serial output is only the 4 buffered words after the current frame.
REQ-037 Assert i_reset_n=0 during data bit 3 of 0x3C -> o_tx=1 and o_txActive=0 with no clock edge; the FIFO is empty; no o_txDone pulse.
REQ-038 With UART_TX_PARITY_EN, write 0x07 -> the parity bit is 1; the frame is 44 cycles; o_txDone pulses in cycle 44.
